// File: rtl/conv_viterbi_decoder_bs.sv
// ---------------------------------------------------------------------------
// conv_viterbi_decoder_bs
//   Hard-decision Viterbi decoder for the LTE tail-biting rate-1/3, K=7
//   convolutional code (generators 133/171/165 octal). It pops byte-wide
//   subblocks d0/d1/d2 from three FIFOs, runs 64-state ACS at one trellis step
//   per cycle, stores survivor decisions, traces back from the best end state
//   and streams decoded bytes out over a valid/ready handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   start, blk_len_sel  block start pulse (IDLE only); 0=SMALL_LEN, 1=MAX_LEN
//   sb_q0/1/2           subblock FIFO data, valid the cycle after sb_rdreq
//   sb_empty0/1/2       FIFO empty flags
//   sb_rdreq            common FIFO read request (decoded from state + flags)
//   dout, dout_valid    decoded byte (MSB = earliest bit) and its valid
//   dout_ready          consumer accepts dout
//   busy, done          not-IDLE indicator; one-cycle end-of-block pulse
//   best_metric         PM of the traceback start state (only when the macro
//                       CONV_DEC_METRIC_OUT_EN is defined)
// ---------------------------------------------------------------------------
module conv_viterbi_decoder_bs #(
  parameter int unsigned MAX_LEN   = 6144,
  parameter int unsigned SMALL_LEN = 1056,
  parameter int unsigned PM_W      = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            blk_len_sel,
  input  logic [7:0]      sb_q0,
  input  logic [7:0]      sb_q1,
  input  logic [7:0]      sb_q2,
  input  logic            sb_empty0,
  input  logic            sb_empty1,
  input  logic            sb_empty2,
  output logic            sb_rdreq,
  output logic [7:0]      dout,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            busy,
  output logic            done
`ifdef CONV_DEC_METRIC_OUT_EN
  ,
  output logic [PM_W-1:0] best_metric
`endif
);

  localparam int unsigned T_W       = $clog2(MAX_LEN + 1);
  localparam int unsigned B_W       = T_W - 3;
  localparam int unsigned NBYTE_MAX = MAX_LEN / 8;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPT, S_ACS, S_MINS, S_TRACE, S_OUT
  } state_e;

  // Expected code triple {d0,d1,d2} for input u leaving predecessor state p
  function automatic logic [2:0] code_bits(input logic u, input logic [5:0] p);
    logic d0, d1, d2;
    d0 = u ^ p[4] ^ p[3] ^ p[1] ^ p[0];
    d1 = u ^ p[5] ^ p[4] ^ p[3] ^ p[0];
    d2 = u ^ p[5] ^ p[4] ^ p[2] ^ p[0];
    return {d0, d1, d2};
  endfunction

  function automatic logic [1:0] hamming3(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] x;
    x = a ^ b;
    return 2'(x[0]) + 2'(x[1]) + 2'(x[2]);
  endfunction

  state_e          state_q, state_d;
  logic [T_W-1:0]  n_q, n_d;
  logic [T_W-1:0]  t_q, t_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      r0_q, r0_d, r1_q, r1_d, r2_q, r2_d;
  logic [PM_W-1:0] pm_q [64];
  logic [PM_W-1:0] pm_d [64];
  logic [5:0]      scan_q, scan_d;
  logic [5:0]      best_idx_q, best_idx_d;
  logic [PM_W-1:0] best_pm_q, best_pm_d;
  logic [5:0]      s_q, s_d;
  logic [7:0]      sr_q, sr_d;
  logic [B_W-1:0]  o_q, o_d;
  logic [7:0]      dout_q, dout_d;
  logic            dout_valid_q, dout_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef CONV_DEC_METRIC_OUT_EN
  logic [PM_W-1:0] best_metric_q, best_metric_d;
`endif

  logic [63:0]     surv_mem [MAX_LEN];
  logic [7:0]      out_mem  [NBYTE_MAX];
  logic [63:0]     surv_rd;
  logic            surv_we, out_we;
  logic            fifo_ok;

  logic [PM_W-1:0] acs_pm [64];
  logic [63:0]     acs_dec;
  logic [2:0]      rx;

  assign fifo_ok  = !(sb_empty0 || sb_empty1 || sb_empty2);
  // Combinational so the pop happens in the very cycle the flags are seen low
  assign sb_rdreq = (state_q == S_FETCH) && fifo_ok;
  assign rx       = {r0_q[bit_q], r1_q[bit_q], r2_q[bit_q]};
  assign surv_rd  = surv_mem[t_q];

  // Add-compare-select for all 64 states; ties resolve to the b=0 predecessor
  always_comb begin
    logic [5:0]      sn, p0, p1;
    logic [PM_W-1:0] m0, m1;
    acs_pm  = '{default: '0};
    acs_dec = '0;
    for (int s = 0; s < 64; s++) begin
      sn = 6'(s);
      p0 = {sn[4:0], 1'b0};
      p1 = {sn[4:0], 1'b1};
      m0 = pm_q[p0] + PM_W'(hamming3(code_bits(sn[5], p0), rx));
      m1 = pm_q[p1] + PM_W'(hamming3(code_bits(sn[5], p1), rx));
      if (m1 < m0) begin
        acs_pm[s]  = m1;
        acs_dec[s] = 1'b1;
      end else begin
        acs_pm[s]  = m0;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    logic [T_W-1:0] t_nxt;
    logic [B_W-1:0] o_nxt;
    state_d      = state_q;
    n_d          = n_q;
    t_d          = t_q;
    bit_d        = bit_q;
    r0_d         = r0_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    pm_d         = pm_q;
    scan_d       = scan_q;
    best_idx_d   = best_idx_q;
    best_pm_d    = best_pm_q;
    s_d          = s_q;
    sr_d         = sr_q;
    o_d          = o_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    done_d       = 1'b0;
    surv_we      = 1'b0;
    out_we       = 1'b0;
    t_nxt        = t_q + 1'b1;
    o_nxt        = o_q + 1'b1;
`ifdef CONV_DEC_METRIC_OUT_EN
    best_metric_d = best_metric_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d     = blk_len_sel ? T_W'(MAX_LEN) : T_W'(SMALL_LEN);
          pm_d    = '{default: '0};
          t_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (fifo_ok) state_d = S_CAPT;
      end
      S_CAPT: begin
        r0_d    = sb_q0;
        r1_d    = sb_q1;
        r2_d    = sb_q2;
        bit_d   = 3'd7;
        state_d = S_ACS;
      end
      S_ACS: begin
        pm_d    = acs_pm;
        surv_we = 1'b1;
        t_d     = t_nxt;
        bit_d   = bit_q - 3'd1;
        if (bit_q == 3'd0) begin
          if (t_nxt < n_q) begin
            state_d = S_FETCH;
          end else begin
            scan_d  = '0;
            state_d = S_MINS;
          end
        end
      end
      S_MINS: begin
        // Strict less-than keeps the lowest index on ties
        if ((scan_q == 6'd0) || (pm_q[scan_q] < best_pm_q)) begin
          best_pm_d  = pm_q[scan_q];
          best_idx_d = scan_q;
        end
        scan_d = scan_q + 6'd1;
        if (scan_q == 6'd63) begin
          s_d     = best_idx_d;
          t_d     = n_q - 1'b1;
          state_d = S_TRACE;
`ifdef CONV_DEC_METRIC_OUT_EN
          best_metric_d = best_pm_d;
`endif
        end
      end
      S_TRACE: begin
        // Bits arrive newest-first, so shift in at the MSB and flush per byte
        sr_d = {s_q[5], sr_q[7:1]};
        s_d  = {s_q[4:0], surv_rd[s_q]};
        if (t_q[2:0] == 3'd0) out_we = 1'b1;
        if (t_q == '0) begin
          o_d     = '0;
          state_d = S_OUT;
        end else begin
          t_d = t_q - 1'b1;
        end
      end
      S_OUT: begin
        if (!dout_valid_q) begin
          dout_d       = out_mem[o_q];
          dout_valid_d = 1'b1;
        end else if (dout_ready) begin
          if (o_q == B_W'((n_q >> 3) - 1'b1)) begin
            dout_d       = '0;
            dout_valid_d = 1'b0;
            done_d       = 1'b1;
            state_d      = S_IDLE;
          end else begin
            o_d    = o_nxt;
            dout_d = out_mem[o_nxt];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      t_q          <= '0;
      bit_q        <= '0;
      r0_q         <= '0;
      r1_q         <= '0;
      r2_q         <= '0;
      pm_q         <= '{default: '0};
      scan_q       <= '0;
      best_idx_q   <= '0;
      best_pm_q    <= '0;
      s_q          <= '0;
      sr_q         <= '0;
      o_q          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef CONV_DEC_METRIC_OUT_EN
      best_metric_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      t_q          <= t_d;
      bit_q        <= bit_d;
      r0_q         <= r0_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      pm_q         <= pm_d;
      scan_q       <= scan_d;
      best_idx_q   <= best_idx_d;
      best_pm_q    <= best_pm_d;
      s_q          <= s_d;
      sr_q         <= sr_d;
      o_q          <= o_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef CONV_DEC_METRIC_OUT_EN
      best_metric_q <= best_metric_d;
`endif
    end
  end

  // Survivor and output byte RAMs (contents not reset)
  always_ff @(posedge clk) begin
    if (surv_we) surv_mem[t_q] <= acs_dec;
    if (out_we)  out_mem[t_q[T_W-1:3]] <= sr_d;
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef CONV_DEC_METRIC_OUT_EN
  assign best_metric = best_metric_q;
`endif

endmodule
